// File: rtl/rr_select_pkg.sv
// rr_select_pkg: shared states, sizes and one-hot helper for the round-robin select arbiter
package rr_select_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_select_arbiter_if.sv
// rr_select_arbiter_if: request/grant bundle between requesting agents and the arbiter
interface rr_select_arbiter_if;
  import rr_select_pkg::*;
  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;
  modport master (output en, req, done, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave (input en, req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_pick8.sv
// rr_pick8: picks the first set request searching upward from ptr+1, wrapping 7->0
module rr_pick8
  import rr_select_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);
  // scanning from the far end down lets the nearest set bit after ptr win
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (i_req[IDX_W'(int'(i_ptr) + k)]) o_idx = IDX_W'(int'(i_ptr) + k);
  end
endmodule

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: round-robin owner of an 8-way one-hot select with hold limit and a dead cycle between grants
module rr_select_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_select_arbiter_if.slave  io_bus
);
  import rr_select_pkg::*;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  state_t           r_state, w_nstate;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_idx, r_ptr, w_pick, w_nidx;
  logic [HW-1:0]    r_hold;
  logic             r_vld, r_timeout;
  logic             w_any, w_win, w_hit, w_rel, w_to;
  rr_pick8 u_pick (
    .i_req (io_bus.req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );
  // timeout only fires when no higher-priority release reason is present
  always_comb begin
    w_win    = (r_state == IDLE) && io_bus.en && w_any;
    w_hit    = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD - 1));
    w_rel    = !io_bus.en || io_bus.done || !io_bus.req[r_idx] || w_hit;
    w_to     = (r_state == GRANT) && io_bus.en && !io_bus.done && io_bus.req[r_idx] && w_hit;
    w_nidx   = w_win ? w_pick : r_idx;
    w_nstate = w_win ? GRANT : (r_state == GRANT) ? (w_rel ? GAP : GRANT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '1;
      r_hold    <= '0;
    end else begin
      r_state   <= w_nstate;
      r_vld     <= w_nstate == GRANT;
      r_gnt     <= (w_nstate == GRANT) ? onehot(w_nidx) : '0;
      r_idx     <= w_nidx;
      r_timeout <= w_to;
      r_ptr     <= w_win ? w_pick : r_ptr;
      r_hold    <= w_win ? '0 : (r_state == GRANT && r_hold != '1) ? r_hold + 1'b1 : r_hold;
    end
  end
  assign io_bus.gnt     = r_gnt;
  assign io_bus.gnt_idx = r_idx;
  assign io_bus.gnt_vld = r_vld;
  assign io_bus.timeout = r_timeout;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter: directed scenarios plus random traffic checked against a behavioural owner model
module tb_rr_select_arbiter;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  rr_select_arbiter_if bus();
  rr_select_arbiter #(.MAX_HOLD(MAX_HOLD), .IDX_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );
  always #5 clk = ~clk;
  int m_owner = -1;
  int m_held = 0;
  int m_gap = 0;
  int m_ptr = 7;
  int m_last = 0;
  bit m_to = 1'b0;
  // model: who owns the select, how long they have held it, and whether a dead cycle is pending
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 7; m_last = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      m_to = 1'b0;
      if (!bus.en || bus.done || !bus.req[m_owner] || (MAX_HOLD > 0 && m_held == MAX_HOLD)) begin
        m_to = bus.en && !bus.done && bus.req[m_owner];
        m_owner = -1;
        m_gap = 1;
      end else m_held++;
    end else if (m_gap != 0) begin
      m_gap = 0;
      m_to = 1'b0;
    end else begin
      int w;
      m_to = 1'b0;
      w = -1;
      for (int k = 1; k <= 8; k++)
        if (w < 0 && bus.req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (bus.en && w >= 0) begin
        m_owner = w; m_held = 1; m_ptr = w; m_last = w;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_last[2:0]));
    chk("gnt_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("onehot", 32'($countones(bus.gnt)), bus.gnt_vld ? 32'd1 : 32'd0);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drv(input logic e, input logic [7:0] r, input logic d);
    bus.en = e; bus.req = r; bus.done = d;
  endtask
  task automatic wait_vld();
    int t;
    t = 0;
    while (!bus.gnt_vld && t < 10) begin cyc(1); t++; end
    chk("wait_vld", 32'(bus.gnt_vld), 32'd1);
  endtask
  initial begin
    int n;
    drv(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_gnt", 32'(bus.gnt), 32'h00);
    chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    drv(1'b1, 8'h01, 1'b0);
    cyc(1);
    chk("t1_gnt", 32'(bus.gnt), 32'h01);
    chk("t1_idx", 32'(bus.gnt_idx), 32'd0);
    cyc(3);
    bus.done = 1'b1;
    cyc(1);
    drv(1'b1, 8'h00, 1'b0);
    chk("t1_gap", 32'(bus.gnt), 32'h00);
    cyc(1);
    chk("t1_idle", 32'(bus.gnt), 32'h00);
    chk("t1_to", 32'(bus.timeout), 32'd0);
    drv(1'b1, 8'h20, 1'b0);
    cyc(1);
    n = 0;
    while (bus.gnt_vld && n < 40) begin n++; cyc(1); end
    chk("t3_hold_len", 32'(n), 32'd16);
    chk("t3_to_pulse", 32'(bus.timeout), 32'd1);
    cyc(1);
    chk("t3_to_clear", 32'(bus.timeout), 32'd0);
    chk("t3_idle", 32'(bus.gnt_vld), 32'd0);
    cyc(1);
    chk("t3_regnt", 32'(bus.gnt), 32'h20);
    chk("t3_regnt_idx", 32'(bus.gnt_idx), 32'd5);
    drv(1'b1, 8'h00, 1'b0);
    cyc(2);
    drv(1'b1, 8'h08, 1'b0);
    cyc(1);
    chk("t4_idx3", 32'(bus.gnt_idx), 32'd3);
    drv(1'b1, 8'h88, 1'b1);
    cyc(1);
    bus.done = 1'b0;
    cyc(2);
    chk("t4_idx7", 32'(bus.gnt_idx), 32'd7);
    chk("t4_vld7", 32'(bus.gnt_vld), 32'd1);
    bus.done = 1'b1;
    cyc(1);
    bus.done = 1'b0;
    cyc(2);
    chk("t4_back3", 32'(bus.gnt_idx), 32'd3);
    drv(1'b1, 8'h00, 1'b0);
    cyc(2);
    drv(1'b1, 8'h04, 1'b0);
    cyc(1);
    chk("t5_idx2", 32'(bus.gnt_idx), 32'd2);
    bus.en = 1'b0;
    cyc(1);
    chk("t5_abort", 32'(bus.gnt_vld), 32'd0);
    chk("t5_no_to", 32'(bus.timeout), 32'd0);
    cyc(2);
    chk("t5_blocked", 32'(bus.gnt_vld), 32'd0);
    bus.en = 1'b1;
    cyc(1);
    chk("t5_resume", 32'(bus.gnt), 32'h04);
    drv(1'b1, 8'h00, 1'b0);
    cyc(2);
    drv(1'b1, 8'h02, 1'b0);
    cyc(1);
    chk("t6_idx1", 32'(bus.gnt_idx), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(bus.gnt), 32'h00);
    chk("t6_async_vld", 32'(bus.gnt_vld), 32'd0);
    @(negedge clk);
    drv(1'b1, 8'h03, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_ptr_reset", 32'(bus.gnt_idx), 32'd0);
    drv(1'b1, 8'h00, 1'b0);
    cyc(2);
    drv(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      wait_vld();
      chk("rr_order", 32'(bus.gnt_idx), 32'((1 + i) % 8));
      cyc(1);
      bus.done = 1'b1;
      cyc(1);
      bus.done = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(5) == 0);
      bus.en = ($urandom_range(19) != 0);
      cyc(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
